reg_pair_sequencer: RTL and testbench

//  Drives the GB80 8-bit register file on behalf of the decoder and executes 16-bit

---
 rtl/reg_pair_sequencer_pkg.sv | 68 ++++++
 rtl/reg_pair_incdec.sv | 15 +
 rtl/reg_pair_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_reg_pair_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_pair_sequencer_pkg.sv
// Shared GB80 register-pair definitions: register, pair and op codes, sequencer
// state encoding and the pair-to-hi/lo register mapping.
package reg_pair_sequencer_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned PAIR_W = 2 * DATA_W;

  typedef enum logic [2:0] {
    OP_RD     = 3'b000,
    OP_WR     = 3'b001,
    OP_INC    = 3'b010,
    OP_DEC    = 3'b011,
    OP_RD_INC = 3'b100,
    OP_RD_DEC = 3'b101,
    OP_RSV6   = 3'b110,
    OP_RSV7   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    PAIR_BC = 2'b00,
    PAIR_DE = 2'b01,
    PAIR_HL = 2'b10,
    PAIR_AF = 2'b11
  } pair_e;

  typedef enum logic [2:0] {
    REG_B = 3'd0,
    REG_C = 3'd1,
    REG_D = 3'd2,
    REG_E = 3'd3,
    REG_H = 3'd4,
    REG_L = 3'd5,
    REG_F = 3'd6,
    REG_A = 3'd7
  } reg_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD_HI  = 3'd1,
    ST_RD_LO  = 3'd2,
    ST_RD_CAP = 3'd3,
    ST_WR_HI  = 3'd4,
    ST_WR_LO  = 3'd5,
    ST_DONE   = 3'd6
  } state_e;

  // High register of a pair: B/D/H/A
  function automatic reg_e pair_hi(input pair_e p);
    case (p)
      PAIR_BC: pair_hi = REG_B;
      PAIR_DE: pair_hi = REG_D;
      PAIR_HL: pair_hi = REG_H;
      default: pair_hi = REG_A;
    endcase
  endfunction

  // Low register of a pair: C/E/L/F
  function automatic reg_e pair_lo(input pair_e p);
    case (p)
      PAIR_BC: pair_lo = REG_C;
      PAIR_DE: pair_lo = REG_E;
      PAIR_HL: pair_lo = REG_L;
      default: pair_lo = REG_F;
    endcase
  endfunction

endpackage

// File: rtl/reg_pair_incdec.sv
// Combinational 16-bit +/-1 with modulo wrap; shared with the SP/PC unit.
module reg_pair_incdec #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_val,
  input  logic             i_dec,
  output logic [WIDTH-1:0] o_val
);

  // Step the value by one in the requested direction
  always_comb begin
    o_val = i_dec ? (i_val - WIDTH'(1)) : (i_val + WIDTH'(1));
  end

endmodule

// File: rtl/reg_pair_sequencer.sv
// GB80 register-pair sequencer: turns 16-bit pair ops into 8-bit register-file
// accesses. Build option: GB80_REGSEQ_POSTSTEP_EN enables RD_INC/RD_DEC
// (read pair, write back pair+/-1, report pre-value); without it those ops
// complete immediately with o_err.
module reg_pair_sequencer
  import reg_pair_sequencer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = DATA_W,
  parameter int unsigned ADDRESS_WIDTH = ADDR_W
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic [2:0]                i_op,
  input  logic [1:0]                i_pair,
  input  logic [2*DATA_WIDTH-1:0]   i_wdata,
  output logic                      o_done,
  output logic [2*DATA_WIDTH-1:0]   o_result,
  output logic                      o_err,
  output logic                      o_rf_wr_en,
  output logic                      o_rf_rd_en,
  output logic [ADDRESS_WIDTH-1:0]  o_rf_addr,
  output logic [DATA_WIDTH-1:0]     o_rf_wdata,
  input  logic [DATA_WIDTH-1:0]     i_rf_rdata
);

  localparam int unsigned PAIR_WIDTH = 2 * DATA_WIDTH;

  state_e                  state_q, state_d;
  op_e                     op_q, op_d;
  pair_e                   pair_q, pair_d;
  logic [PAIR_WIDTH-1:0]   data_q, data_d;
  logic [PAIR_WIDTH-1:0]   res_q, res_d;
  logic                    err_q, err_d;

  logic                    ready_d, done_d, err_out_d;
  logic [PAIR_WIDTH-1:0]   result_d;
  logic                    rd_en_d, wr_en_d;
  logic [ADDRESS_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0]   wdata_d;

  logic [PAIR_WIDTH-1:0]   rd_val;
  logic [PAIR_WIDTH-1:0]   step_val;
  logic                    step_dec;

  // F keeps its low nibble clear whenever AF is written
  function automatic logic [PAIR_WIDTH-1:0] af_mask(input logic [PAIR_WIDTH-1:0] v,
                                                    input pair_e p);
    af_mask = v;
    if (p == PAIR_AF) af_mask[3:0] = 4'h0;
  endfunction

  // Full pair as read: captured high byte plus low byte arriving now
  always_comb begin
    rd_val = {data_q[PAIR_WIDTH-1:DATA_WIDTH], i_rf_rdata};
`ifdef GB80_REGSEQ_POSTSTEP_EN
    step_dec = (op_q == OP_DEC) || (op_q == OP_RD_DEC);
`else
    step_dec = (op_q == OP_DEC);
`endif
  end

  reg_pair_incdec #(.WIDTH(PAIR_WIDTH)) u_incdec (
    .i_val (rd_val),
    .i_dec (step_dec),
    .o_val (step_val)
  );

  // Next state, operand capture and next registered outputs
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    pair_d    = pair_q;
    data_d    = data_q;
    res_d     = res_q;
    err_d     = err_q;
    rd_en_d   = 1'b0;
    wr_en_d   = 1'b0;
    addr_d    = '0;
    wdata_d   = '0;

    case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          op_d   = op_e'(i_op);
          pair_d = pair_e'(i_pair);
          err_d  = 1'b0;
          data_d = '0;
          res_d  = '0;
          case (op_e'(i_op))
            OP_RD, OP_INC, OP_DEC: state_d = ST_RD_HI;
`ifdef GB80_REGSEQ_POSTSTEP_EN
            OP_RD_INC, OP_RD_DEC: state_d = ST_RD_HI;
`endif
            OP_WR: begin
              data_d  = af_mask(i_wdata, pair_e'(i_pair));
              res_d   = data_d;
              state_d = ST_WR_HI;
            end
            default: begin
              err_d   = 1'b1;
              state_d = ST_DONE;
            end
          endcase
        end
      end
      ST_RD_HI: state_d = ST_RD_LO;
      ST_RD_LO: begin
        data_d[PAIR_WIDTH-1:DATA_WIDTH] = i_rf_rdata;
        state_d = ST_RD_CAP;
      end
      ST_RD_CAP: begin
        if (op_q == OP_RD) begin
          data_d  = rd_val;
          res_d   = rd_val;
          state_d = ST_DONE;
        end else begin
          data_d  = af_mask(step_val, pair_q);
`ifdef GB80_REGSEQ_POSTSTEP_EN
          res_d   = ((op_q == OP_RD_INC) || (op_q == OP_RD_DEC)) ? rd_val : data_d;
`else
          res_d   = data_d;
`endif
          state_d = ST_WR_HI;
        end
      end
      ST_WR_HI: state_d = ST_WR_LO;
      ST_WR_LO: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    ready_d   = (state_d == ST_IDLE);
    done_d    = (state_d == ST_DONE);
    err_out_d = done_d && err_d;
    result_d  = done_d ? res_d : '0;

    case (state_d)
      ST_RD_HI: begin
        rd_en_d = 1'b1;
        addr_d  = ADDRESS_WIDTH'(pair_hi(pair_d));
      end
      ST_RD_LO: begin
        rd_en_d = 1'b1;
        addr_d  = ADDRESS_WIDTH'(pair_lo(pair_d));
      end
      ST_WR_HI: begin
        wr_en_d = 1'b1;
        addr_d  = ADDRESS_WIDTH'(pair_hi(pair_d));
        wdata_d = data_d[PAIR_WIDTH-1:DATA_WIDTH];
      end
      ST_WR_LO: begin
        wr_en_d = 1'b1;
        addr_d  = ADDRESS_WIDTH'(pair_lo(pair_d));
        wdata_d = data_d[DATA_WIDTH-1:0];
      end
      default: ;
    endcase
  end

  // State, operand and output registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_RD;
      pair_q     <= PAIR_BC;
      data_q     <= '0;
      res_q      <= '0;
      err_q      <= 1'b0;
      o_ready    <= 1'b1;
      o_done     <= 1'b0;
      o_err      <= 1'b0;
      o_result   <= '0;
      o_rf_rd_en <= 1'b0;
      o_rf_wr_en <= 1'b0;
      o_rf_addr  <= '0;
      o_rf_wdata <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      pair_q     <= pair_d;
      data_q     <= data_d;
      res_q      <= res_d;
      err_q      <= err_d;
      o_ready    <= ready_d;
      o_done     <= done_d;
      o_err      <= err_out_d;
      o_result   <= result_d;
      o_rf_rd_en <= rd_en_d;
      o_rf_wr_en <= wr_en_d;
      o_rf_addr  <= addr_d;
      o_rf_wdata <= wdata_d;
    end
  end

endmodule

// File: tb/tb_reg_pair_sequencer.sv
// Self-checking bench for reg_pair_sequencer with a behavioural register file
// and a pair-level reference model. Honours GB80_REGSEQ_POSTSTEP_EN.
module tb_reg_pair_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [2:0]  i_op = 3'd0;
  logic [1:0]  i_pair = 2'd0;
  logic [15:0] i_wdata = 16'h0;
  logic        o_done;
  logic [15:0] o_result;
  logic        o_err;
  logic        rf_wr_en, rf_rd_en;
  logic [2:0]  rf_addr;
  logic [7:0]  rf_wdata;
  logic [7:0]  rf_rdata = 8'h00;

  int checks = 0;
  int failures = 0;

  logic [7:0] rf       [8] = '{default: 8'h00};
  logic [7:0] ref_regs [8] = '{default: 8'h00};
  int hi_idx [4] = '{0, 2, 4, 7};
  int lo_idx [4] = '{1, 3, 5, 6};

  int rd_cnt = 0, wr_cnt = 0;
  int rd_base = 0, wr_base = 0;

  logic [15:0] e_res;
  logic        e_err;
  int          e_lat, e_rd, e_wr;

  reg_pair_sequencer dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_op       (i_op),
    .i_pair     (i_pair),
    .i_wdata    (i_wdata),
    .o_done     (o_done),
    .o_result   (o_result),
    .o_err      (o_err),
    .o_rf_wr_en (rf_wr_en),
    .o_rf_rd_en (rf_rd_en),
    .o_rf_addr  (rf_addr),
    .o_rf_wdata (rf_wdata),
    .i_rf_rdata (rf_rdata)
  );

  always #5 clk = ~clk;

  // Register file: synchronous write, read data valid the cycle after rd_en
  always @(posedge clk) begin
    if (rf_wr_en) rf[rf_addr] <= rf_wdata;
    if (rf_rd_en) rf_rdata <= rf[rf_addr];
  end

  // Strobe activity counters
  always @(negedge clk) begin
    if (rf_rd_en) rd_cnt <= rd_cnt + 1;
    if (rf_wr_en) wr_cnt <= wr_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] pair_val(input int p);
    return {ref_regs[hi_idx[p]], ref_regs[lo_idx[p]]};
  endfunction

  task automatic pair_store(input int p, input logic [15:0] v);
    logic [15:0] m;
    m = v;
    if (p == 3) m[3:0] = 4'h0;
    ref_regs[hi_idx[p]] = m[15:8];
    ref_regs[lo_idx[p]] = m[7:0];
  endtask

  // Reference model: applies op to the model registers, returns expectations
  task automatic model_exec(input int op, input int p, input logic [15:0] wd);
    logic [15:0] v;
    logic legal_post;
`ifdef GB80_REGSEQ_POSTSTEP_EN
    legal_post = 1'b1;
`else
    legal_post = 1'b0;
`endif
    v = pair_val(p);
    e_err = 1'b0;
    if (op == 0) begin
      e_res = v; e_lat = 4; e_rd = 2; e_wr = 0;
    end else if (op == 1) begin
      pair_store(p, wd); e_res = pair_val(p); e_lat = 3; e_rd = 0; e_wr = 2;
    end else if (op == 2 || op == 3) begin
      pair_store(p, (op == 2) ? v + 16'd1 : v - 16'd1);
      e_res = pair_val(p); e_lat = 6; e_rd = 2; e_wr = 2;
    end else if ((op == 4 || op == 5) && legal_post) begin
      pair_store(p, (op == 4) ? v + 16'd1 : v - 16'd1);
      e_res = v; e_lat = 6; e_rd = 2; e_wr = 2;
    end else begin
      e_res = 16'h0; e_err = 1'b1; e_lat = 1; e_rd = 0; e_wr = 0;
    end
  endtask

  // Present a request and return just after the accepting edge
  task automatic issue(input int op, input int p, input logic [15:0] wd);
    @(negedge clk);
    chk("ready_idle", 32'(o_ready), 32'd1);
    i_valid = 1'b1;
    i_op    = 3'(op);
    i_pair  = 2'(p);
    i_wdata = wd;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_op    = 3'($urandom);
    i_pair  = 2'($urandom);
    i_wdata = 16'($urandom);
    rd_base = rd_cnt;
    wr_base = wr_cnt;
  endtask

  // Wait (bounded) for o_done and check result, latency, strobes and pair
  task automatic wait_done(input int k0, input int p);
    int k;
    bit seen;
    k = k0;
    seen = 1'b0;
    while (k < 20 && !seen) begin
      @(negedge clk);
      k++;
      chk("ready_busy", 32'(o_ready), 32'd0);
      chk("strobe_excl", 32'(rf_rd_en & rf_wr_en), 32'd0);
      if (o_done) seen = 1'b1;
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("latency", 32'(k), 32'(e_lat));
    chk("result", 32'(o_result), 32'(e_res));
    chk("err", 32'(o_err), 32'(e_err));
    chk("rd_strobes", 32'(rd_cnt - rd_base), 32'(e_rd));
    chk("wr_strobes", 32'(wr_cnt - wr_base), 32'(e_wr));
    chk("rf_pair", 32'({rf[hi_idx[p]], rf[lo_idx[p]]}), 32'(pair_val(p)));
  endtask

  task automatic do_op(input int op, input int p, input logic [15:0] wd);
    issue(op, p, wd);
    model_exec(op, p, wd);
    wait_done(0, p);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_err", 32'(o_err), 32'd0);
    chk("rst_result", 32'(o_result), 32'd0);
    chk("rst_strobes", 32'({rf_rd_en, rf_wr_en}), 32'd0);
    chk("rst_addr", 32'(rf_addr), 32'd0);
    chk("rst_wdata", 32'(rf_wdata), 32'd0);
    rst = 1'b0;

    // WR BC=1234 with strobe timing, then RD BC
    issue(1, 0, 16'h1234);
    model_exec(1, 0, 16'h1234);
    @(negedge clk);
    chk("wr_hi_strobe", 32'({rf_wr_en, rf_addr, rf_wdata}), 32'({1'b1, 3'd0, 8'h12}));
    @(negedge clk);
    chk("wr_lo_strobe", 32'({rf_wr_en, rf_addr, rf_wdata}), 32'({1'b1, 3'd1, 8'h34}));
    wait_done(2, 0);
    do_op(0, 0, 16'h0);

    // HL wrap on INC then DEC
    do_op(1, 2, 16'hFFFF);
    do_op(2, 2, 16'h0);
    chk("hl_after_inc", 32'({rf[4], rf[5]}), 32'h0000);
    do_op(3, 2, 16'h0);

    // AF masking
    do_op(1, 3, 16'h12FF);
    chk("f_masked", 32'(rf[6]), 32'hF0);
    do_op(0, 3, 16'h0);

    // Busy: held request with a new op is ignored until after DONE
    issue(0, 1, 16'h0);
    model_exec(0, 1, 16'h0);
    i_valid = 1'b1;
    i_op    = 3'd1;
    i_pair  = 2'd1;
    i_wdata = 16'h5A5A;
    wait_done(0, 1);
    @(negedge clk);
    chk("ready_after_done", 32'(o_ready), 32'd1);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    rd_base = rd_cnt;
    wr_base = wr_cnt;
    model_exec(1, 1, 16'h5A5A);
    wait_done(0, 1);

    // Post-step read (or illegal when the option is off)
    do_op(1, 2, 16'hC000);
    do_op(4, 2, 16'h0);
    do_op(5, 2, 16'h0);
    do_op(6, 0, 16'h0);
    do_op(7, 3, 16'h0);

    // Reset during WR_LO leaves the pair half-written
    do_op(1, 1, 16'h1111);
    issue(1, 1, 16'hABCD);
    @(negedge clk);
    @(negedge clk);
    chk("in_wr_lo", 32'({rf_wr_en, rf_addr}), 32'({1'b1, 3'd3}));
    rst = 1'b1;
    #1;
    chk("rst_mid_strobes", 32'({rf_rd_en, rf_wr_en, rf_addr, rf_wdata}), 32'd0);
    chk("rst_mid_done", 32'({o_done, o_err, o_result}), 32'd0);
    chk("rst_mid_ready", 32'(o_ready), 32'd1);
    ref_regs[2] = 8'hAB;
    @(negedge clk);
    rst = 1'b0;
    chk("half_written", 32'({rf[2], rf[3]}), 32'hAB11);
    @(negedge clk);
    chk("ready_post_rst", 32'(o_ready), 32'd1);

    // Randomized ops against the model
    for (int i = 0; i < 40; i++) begin
      do_op(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), 16'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
